// File: rtl/bg_pkg.sv
// Shared constants and types for the background frame-buffer blitter.
// Exports: frame-buffer geometry, the command FSM state enum, the registered
// command record, and a helper that flags zero-area commands.
package bg_pkg;

  localparam int FB_WIDTH   = 320;
  localparam int FB_HEIGHT  = 240;
  localparam int ADDR_W     = 17;
  localparam int SRC_ADDR_W = 19;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

  typedef struct packed {
    logic                  mode;      // 0 = fill, 1 = copy
    logic [8:0]            x;
    logic [7:0]            y;
    logic [8:0]            w;
    logic [7:0]            h;
    logic [3:0]            color;
    logic [SRC_ADDR_W-1:0] src_base;
  } blit_cmd_t;

  // A rectangle with no area produces no pixels at all.
  function automatic logic is_degenerate(input logic [8:0] w, input logic [7:0] h);
    return (w == 9'd0) || (h == 8'd0);
  endfunction

endpackage

// File: rtl/bg_addr_gen.sv
// Stage-1 address generator: maps the (i, j) pixel counters of the current
// rectangle onto frame-buffer coordinates, a clip flag, the flat write address
// and the sprite-ROM read pointer. Purely combinational.
// Ports: x_i/y_i/w_i/h_i/src_base_i (registered command), i_i/j_i/k_i counters;
//        px_o/py_o, clip_o, fb_addr_o, src_addr_o, last_col_o/last_row_o.
module bg_addr_gen #(
  parameter int FB_WIDTH   = bg_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = bg_pkg::FB_HEIGHT,
  parameter int ADDR_W     = bg_pkg::ADDR_W,
  parameter int SRC_ADDR_W = bg_pkg::SRC_ADDR_W
) (
  input  logic [8:0]            x_i,
  input  logic [7:0]            y_i,
  input  logic [8:0]            w_i,
  input  logic [7:0]            h_i,
  input  logic [SRC_ADDR_W-1:0] src_base_i,
  input  logic [8:0]            i_i,
  input  logic [7:0]            j_i,
  input  logic [SRC_ADDR_W-1:0] k_i,
  output logic [9:0]            px_o,
  output logic [8:0]            py_o,
  output logic                  clip_o,
  output logic [ADDR_W-1:0]     fb_addr_o,
  output logic [SRC_ADDR_W-1:0] src_addr_o,
  output logic                  last_col_o,
  output logic                  last_row_o
);
  import bg_pkg::*;

  // One extra bit on each coordinate so rectangles running off the right or
  // bottom edge are detected instead of wrapping back onto the screen.
  assign px_o   = {1'b0, x_i} + {1'b0, i_i};
  assign py_o   = {1'b0, y_i} + {1'b0, j_i};
  assign clip_o = (px_o >= 10'(FB_WIDTH)) || (py_o >= 9'(FB_HEIGHT));

  // Constant multiply; synthesis reduces it to shift-add. Clipped pixels may
  // produce out-of-range addresses but are never written.
  assign fb_addr_o = ADDR_W'(py_o) * ADDR_W'(FB_WIDTH) + ADDR_W'(px_o);

  // The source rectangle is stored densely, so a linear pointer suffices.
  assign src_addr_o = src_base_i + k_i;

  assign last_col_o = (i_i == w_i - 9'd1);
  assign last_row_o = (j_i == h_i - 8'd1);

endmodule

// File: rtl/background_writer.sv
// Blit engine writing fill/copy rectangles of 4-bit palette indices into the
// 320x240 background frame buffer at one pixel per clock (2-stage pipeline).
// Ports: cmd_* handshake/fields in, src_address/src_data sprite ROM port,
//        wr_en/wr_address/wr_data frame-buffer write port, busy/done status.
module background_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int ADDR_W     = 17,
  parameter int SRC_ADDR_W = 19
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_mode,
  input  logic [8:0]            cmd_x,
  input  logic [7:0]            cmd_y,
  input  logic [8:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [3:0]            cmd_color,
  input  logic [SRC_ADDR_W-1:0] cmd_src_base,
  output logic [SRC_ADDR_W-1:0] src_address,
  input  logic [3:0]            src_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_address,
  output logic [3:0]            wr_data,
  output logic                  busy,
  output logic                  done
);
  import bg_pkg::*;

  state_t                state_q;
  blit_cmd_t             cmd_q;
  logic [8:0]            i_q;
  logic [7:0]            j_q;
  logic [SRC_ADDR_W-1:0] k_q;

  // Stage-2 pipeline registers plus the last committed write, which the
  // write port presents whenever no write is happening.
  logic                  s2_vld_q;
  logic                  s2_clip_q;
  logic [ADDR_W-1:0]     s2_addr_q;
  logic [ADDR_W-1:0]     last_addr_q;
  logic [3:0]            last_data_q;

  logic [9:0]            px;
  logic [8:0]            py;
  logic                  clip;
  logic [ADDR_W-1:0]     fb_addr;
  logic                  last_col;
  logic                  last_row;
  logic [3:0]            pix_data;

  bg_addr_gen #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .ADDR_W    (ADDR_W),
    .SRC_ADDR_W(SRC_ADDR_W)
  ) u_addr_gen (
    .x_i       (cmd_q.x),
    .y_i       (cmd_q.y),
    .w_i       (cmd_q.w),
    .h_i       (cmd_q.h),
    .src_base_i(cmd_q.src_base),
    .i_i       (i_q),
    .j_i       (j_q),
    .k_i       (k_q),
    .px_o      (px),
    .py_o      (py),
    .clip_o    (clip),
    .fb_addr_o (fb_addr),
    .src_addr_o(src_address),
    .last_col_o(last_col),
    .last_row_o(last_row)
  );

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

  // Copy data arrives from the ROM in the stage-2 cycle itself, so the
  // write strobe and data are resolved combinationally against src_data.
  // The command record is stable until the next accept, which covers DRAIN.
  assign pix_data   = cmd_q.mode ? src_data : cmd_q.color;
  assign wr_en      = s2_vld_q && !s2_clip_q && !(cmd_q.mode && (src_data == 4'd0));
  assign wr_address = wr_en ? s2_addr_q : last_addr_q;
  assign wr_data    = wr_en ? pix_data : last_data_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      s2_vld_q    <= 1'b0;
      s2_clip_q   <= 1'b0;
      s2_addr_q   <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      s2_vld_q <= 1'b0;
      if (wr_en) begin
        last_addr_q <= wr_address;
        last_data_q <= wr_data;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q.mode     <= cmd_mode;
            cmd_q.x        <= cmd_x;
            cmd_q.y        <= cmd_y;
            cmd_q.w        <= cmd_w;
            cmd_q.h        <= cmd_h;
            cmd_q.color    <= cmd_color;
            cmd_q.src_base <= cmd_src_base;
            i_q            <= '0;
            j_q            <= '0;
            k_q            <= '0;
            state_q        <= is_degenerate(cmd_w, cmd_h) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          s2_vld_q  <= 1'b1;
          s2_clip_q <= clip;
          s2_addr_q <= fb_addr;
          k_q       <= k_q + SRC_ADDR_W'(1);
          if (last_col) begin
            i_q <= '0;
            if (last_row) state_q <= DRAIN;
            else          j_q     <= j_q + 8'd1;
          end else begin
            i_q <= i_q + 9'd1;
          end
        end
        DRAIN:   state_q <= FINISH;
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
